// File: rtl/draw_text_box.sv
// Text box overlay: 17x28 characters of 8x16 pixels drawn at (XPOS, YPOS) over the pixel stream.
// Optional TEXT_BLINK_EN adds a vsync-driven frame counter that blinks the text (32 on / 32 off).
module draw_text_box #(
  parameter logic [10:0] XPOS         = 11'd0,
  parameter logic [10:0] YPOS         = 11'd0,
  parameter logic [11:0] LETTER_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [9:0]  char_yx,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [10:0] BoxW = 11'd136;
  localparam logic [10:0] BoxH = 11'd448;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        in_box;
    logic [2:0]  sub_x;
  } pix_t;

  logic [10:0] rel_x;
  logic [10:0] rel_y;
  logic        in_box;
  logic        text_visible;
  logic        glyph_on;
  pix_t        pix_in;
  pix_t        pipe_q [3];
  logic [3:0]  line_q;

  always_comb begin
    rel_x  = hcount_in - XPOS;
    rel_y  = vcount_in - YPOS;
    in_box = (hcount_in >= XPOS) && (rel_x < BoxW) && (vcount_in >= YPOS) && (rel_y < BoxH);
    pix_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in, vsync: vsync_in,
               hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in, in_box: in_box,
               sub_x: rel_x[2:0]};
  end

  // Stage 3 meets the font ROM row for the same pixel; bit 7 is the leftmost column.
  always_comb begin
    glyph_on = pipe_q[2].in_box && text_visible && char_pixels[3'd7 - pipe_q[2].sub_x];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q[0] <= '0;
      pipe_q[1] <= '0;
      pipe_q[2] <= '0;
      line_q    <= '0;
      char_yx   <= '0;
      char_line <= '0;
    end else begin
      pipe_q[0] <= pix_in;
      pipe_q[1] <= pipe_q[0];
      pipe_q[2] <= pipe_q[1];
      line_q    <= in_box ? rel_y[3:0] : 4'h0;
      char_yx   <= in_box ? {rel_y[8:4], rel_x[7:3]} : 10'h000;
      char_line <= line_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= pipe_q[2].hcount;
      vcount_out <= pipe_q[2].vcount;
      hsync_out  <= pipe_q[2].hsync;
      vsync_out  <= pipe_q[2].vsync;
      hblnk_out  <= pipe_q[2].hblnk;
      vblnk_out  <= pipe_q[2].vblnk;
      rgb_out    <= glyph_on ? LETTER_COLOR : pipe_q[2].rgb;
    end
  end

`ifdef TEXT_BLINK_EN
  logic [5:0] frame_cnt_q;
  logic       vsync_prev_q;

  // Counter is only read at the output stage, so a frame edge switches whole pixels cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q  <= '0;
      vsync_prev_q <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_in;
      if (vsync_in && !vsync_prev_q) frame_cnt_q <= frame_cnt_q + 6'd1;
    end
  end

  always_comb text_visible = ~frame_cnt_q[5];
`else
  always_comb text_visible = 1'b1;
`endif

endmodule

// File: tb/tb_draw_text_box.sv
// Randomized bench for draw_text_box with a per-slot arithmetic reference model of the text box.
module tb_draw_text_box;

  localparam int          X0 = 100;
  localparam int          Y0 = 50;
  localparam logic [11:0] LC = 12'h5A3;
  localparam int          MaxSlots = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [9:0]  char_yx;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_text_box #(
    .XPOS        (11'd100),
    .YPOS        (11'd50),
    .LETTER_COLOR(LC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .char_yx    (char_yx),
    .char_line  (char_line),
    .char_pixels(char_pixels),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t = 0;

  // Per-slot history of what was driven, plus model blink visibility at that slot's edge.
  int         s_h   [MaxSlots];
  int         s_v   [MaxSlots];
  logic [3:0] s_sync[MaxSlots];
  logic [11:0] s_rgb[MaxSlots];
  logic [7:0] s_px  [MaxSlots];
  bit         s_rst [MaxSlots];
  bit         s_vis [MaxSlots];
  int         m_frames = 0;
  bit         m_prev_vs = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s slot=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic bit m_inbox(int h, int v);
    return (h >= X0) && (h - X0 < 136) && (v >= Y0) && (v - Y0 < 448);
  endfunction

  function automatic bit rst_win(int lo, int hi);
    for (int i = lo; i <= hi; i++) if (i < 0 || s_rst[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input int h, input int v, input logic hs, input logic vs, input logic hb,
                      input logic vb, input logic [11:0] rgb, input logic [7:0] px,
                      input bit r);
    int j;
    int rx;
    bit glyph;
    logic [31:0] exp_rgb;
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    rgb_in = rgb; char_pixels = px; rst = r;
    s_h[t] = h; s_v[t] = v; s_sync[t] = {hs, vs, hb, vb}; s_rgb[t] = rgb;
    s_px[t] = px; s_rst[t] = r;
`ifdef TEXT_BLINK_EN
    s_vis[t] = (m_frames % 64) < 32;
`else
    s_vis[t] = 1'b1;
`endif
    @(posedge clk);
    #1;
    if (r) begin
      m_frames = 0; m_prev_vs = 1'b0;
    end else begin
      if (vs && !m_prev_vs) m_frames++;
      m_prev_vs = vs;
    end
    // char_yx follows this slot, char_line the previous one, pixel outputs three slots back.
    if (rst_win(t, t)) check("char_yx", 32'(char_yx), 0);
    else check("char_yx", 32'(char_yx),
               m_inbox(h, v) ? 32'((((v - Y0) / 16) << 5) | ((h - X0) / 8)) : 0);
    j = t - 1;
    if (rst_win(j, t)) check("char_line", 32'(char_line), 0);
    else check("char_line", 32'(char_line),
               m_inbox(s_h[j], s_v[j]) ? 32'((s_v[j] - Y0) % 16) : 0);
    j = t - 3;
    if (rst_win(j, t)) begin
      check("rgb_out_rst", 32'(rgb_out), 0);
      check("timing_rst", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
            0);
    end else begin
      rx = s_h[j] - X0;
      glyph = m_inbox(s_h[j], s_v[j]) && s_vis[t] && s_px[t][7 - (rx % 8)];
      exp_rgb = glyph ? 32'(LC) : 32'(s_rgb[j]);
      check("rgb_out", 32'(rgb_out), exp_rgb);
      check("hcount_out", 32'(hcount_out), 32'(s_h[j]));
      check("vcount_out", 32'(vcount_out), 32'(s_v[j]));
      check("sync_blank_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
            32'(s_sync[j]));
    end
    t++;
  endtask

  task automatic idle(input logic vs, input logic [7:0] px);
    step(20, 20, 1'b0, vs, 1'b1, 1'b0, 12'h111, px, 1'b0);
  endtask

  task automatic glyph_probe(input string tag);
    bit vis;
`ifdef TEXT_BLINK_EN
    vis = (m_frames % 64) < 32;
`else
    vis = 1'b1;
`endif
    step(100, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 8'h00, 1'b0);
    idle(1'b0, 8'h00);
    idle(1'b0, 8'h00);
    idle(1'b0, 8'h80);
    check(tag, 32'(rgb_out), vis ? 32'(LC) : 32'h0F0);
  endtask

  initial begin
    int h;
    int v;
    logic vs_r;
    // Reset held with active inputs: everything must read zero.
    for (int i = 0; i < 3; i++) step(143, 89, 1'b1, 1'b0, 1'b1, 1'b1, 12'hABC, 8'hFF, 1'b1);

    // Corner of a character cell: rel=(43,39) gives row 2, column 5, glyph line 7.
    step(143, 89, 1'b1, 1'b0, 1'b0, 1'b0, 12'h321, 8'h00, 1'b0);
    check("req029_char_yx", 32'(char_yx), 32'h045);
    step(101, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 8'h00, 1'b0);
    check("req029_char_line", 32'(char_line), 32'h7);

    // Leftmost glyph column lit vs next column dark with the same font row.
    step(100, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 8'h00, 1'b0);
    step(101, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 8'h00, 1'b0);
    idle(1'b0, 8'h00);
    idle(1'b0, 8'h80);
    check("req030_lit", 32'(rgb_out), 32'(LC));
    idle(1'b0, 8'h80);
    check("req030_dark", 32'(rgb_out), 32'h789);

    // Right and top edges just outside the box.
    step(236, 60, 1'b1, 1'b0, 1'b0, 1'b0, 12'hE01, 8'hFF, 1'b0);
    check("req031_right_yx", 32'(char_yx), 0);
    step(150, 49, 1'b0, 1'b1, 1'b0, 1'b1, 12'hE02, 8'hFF, 1'b0);
    check("req031_top_yx", 32'(char_yx), 0);
    idle(1'b0, 8'hFF);
    idle(1'b0, 8'hFF);
    check("req031_right_rgb", 32'(rgb_out), 32'hE01);
    idle(1'b0, 8'hFF);
    check("req031_top_rgb", 32'(rgb_out), 32'hE02);
    check("req031_vcount", 32'(vcount_out), 49);

    // Blink: 32 frames hides the text when the counter is built in, 64 frames restores it.
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
    for (int f = 0; f < 32; f++) begin
      idle(1'b1, 8'h00);
      idle(1'b0, 8'h00);
    end
    glyph_probe("blink_32");
    for (int f = 0; f < 32; f++) begin
      idle(1'b1, 8'h00);
      idle(1'b0, 8'h00);
    end
    glyph_probe("blink_64");

    // Randomized traffic around the box edges, with occasional resets and frame pulses.
    vs_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        h = ($urandom_range(1) == 0) ? 99 + $urandom_range(1) : 235 + $urandom_range(1);
        v = ($urandom_range(1) == 0) ? 49 + $urandom_range(1) : 497 + $urandom_range(1);
      end else begin
        h = $urandom_range(245, 90);
        v = $urandom_range(510, 40);
      end
      if ($urandom_range(3) == 0) vs_r = ~vs_r;
      step(h, v, 1'($urandom), vs_r, 1'($urandom), 1'($urandom), 12'($urandom),
           8'($urandom), $urandom_range(199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/draw_text_box.md
DRAW_TEXT_BOX -- requirements
Module: draw_text_box

Interface
REQ-001 Parameter XPOS, 11'd0, left pixel column of the text box.
REQ-002 Parameter YPOS, 11'd0, top pixel row of the text box.
REQ-003 Parameter LETTER_COLOR, 12'hFFF, rgb value for set glyph pixels.
REQ-004 clk  in  1  pixel clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 hcount_in, vcount_in  in  11 each  pixel position from the upstream timing stage.
REQ-007 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  upstream sync/blank.
REQ-008 rgb_in  in  12  upstream pixel colour.
REQ-009 char_yx  out  10  {char_y[4:0], char_x[4:0]}, address to the 17x28 character-code ROM.
REQ-010 char_line  out  4  glyph row (0-15), address low bits to the 8x16 font ROM.
REQ-011 char_pixels  in  8  font ROM row, bit 7 = leftmost pixel.
REQ-012 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  11/11/1/1/1/1/12  delayed timing and composed colour.

Function
REQ-013 Box geometry SHALL be 17 chars x 28 rows of 8x16 px: 136 x 448 px at (XPOS, YPOS).
REQ-014 rel_x = hcount_in - XPOS, rel_y = vcount_in - YPOS; in_box SHALL be hcount_in >= XPOS, rel_x < 136, vcount_in >= YPOS, rel_y < 448 (unsigned compares, no wrap).
REQ-015 At cycle N+1 char_yx SHALL equal {rel_y[8:4], rel_x[7:3]} when in_box, else 10'h000.
REQ-016 At cycle N+2 char_line SHALL equal rel_y[3:0] of the cycle-N sample (aligned with the char ROM's registered code), 4'h0 outside box.
REQ-017 char_pixels SHALL be sampled at cycle N+3 as belonging to the cycle-N input sample (1-cycle char ROM + 1-cycle font ROM).
REQ-018 in_box, rel_x[2:0] and all timing/rgb inputs SHALL be delayed through a 3-stage register pipeline to align with char_pixels.
REQ-019 All outputs SHALL be registered; total input-to-output latency exactly 4 clock cycles for every timing signal and rgb.
REQ-020 rgb_out SHALL be LETTER_COLOR when delayed in_box = 1, text visible, and char_pixels[7 - rel_x[2:0]] = 1; otherwise delayed rgb_in unchanged.
REQ-021 Blanking SHALL NOT be modified; hblnk/vblnk pixels inside box still pass rgb_in when glyph bit = 0 and are overwritten only per REQ-020.
REQ-022 Pipeline SHALL accept a new pixel every cycle; no stalls, no handshake.

Reset
REQ-023 While rst = 1 at a clock edge, all outputs, pipeline stages and counters SHALL be 0 on that edge.
REQ-024 Reset mid-frame SHALL clear the pipeline; outputs resume valid data 4 cycles after rst deasserts.

Configuration
REQ-025 Macro TEXT_BLINK_EN: when defined, a 6-bit frame counter SHALL increment on each vsync_in 0->1 edge (edge detect by registered previous vsync_in, cleared by reset, wraps 63->0).
REQ-026 With TEXT_BLINK_EN, text visible SHALL equal counter[5] == 0 (32 frames on, 32 off); counter updates SHALL not glitch mid-pixel pipeline.
REQ-027 Without TEXT_BLINK_EN, text visible SHALL be constant 1 and no counter or edge detector SHALL be synthesised.

Verification
REQ-028 rst=1 3 cycles with active inputs -> all outputs 0; after release, first valid rgb_out 4 cycles later.
REQ-029 XPOS=100,YPOS=50; hcount_in=143, vcount_in=89 -> char_yx=10'h045 at N+1, char_line=4'h7 at N+2.
REQ-030 hcount_in=100 (rel_x[2:0]=0), in box, char_pixels=8'h80 at N+3 -> rgb_out=LETTER_COLOR at N+4; hcount_in=101 same pixels -> rgb_out=rgb_in of N.
REQ-031 hcount_in=236 (rel_x=136) or vcount_in=49 -> char_yx=10'h000, rgb_out=rgb_in of N; hsync_out/vcount_out equal inputs delayed by 4.
REQ-032 TEXT_BLINK_EN defined: 32 vsync rising edges -> glyph pixels suppressed (rgb_out=rgb_in); 64 edges -> glyphs restored; undefined: glyphs shown at all counts.
